// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, ALU and
// mux select codes, and the controller state enum.
package mips_pkg;

    // Opcodes (IR[31:26]) understood by the controller
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ALUOp encodings
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // ALUSrcB encodings
    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // PCSource encodings
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Controller states; encodings 10..15 are unused
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9
    } state_t;

endpackage

// File: rtl/mc_output_decode.sv
// Moore control decode: current state (plus mem_ready for the memory
// handshake states) to every datapath mux select and write enable.
module mc_output_decode
    import mips_pkg::*;
(
    input  logic [3:0] state_i,
    input  logic       mem_ready_i,
    input  logic [5:0] opcode_i,
    output logic       pc_write_o,
    output logic       pc_write_cond_o,
    output logic       iord_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic       mem_to_reg_o,
    output logic       reg_dst_o,
    output logic       reg_write_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] alu_op_o,
    output logic [1:0] pc_source_o,
    output logic       instr_done_o,
    output logic       illegal_op_o
);

    logic op_known;

    // Opcode classes the controller can sequence
    always_comb begin
        op_known = (opcode_i == OP_LW)  || (opcode_i == OP_SW) ||
                   (opcode_i == OP_RTYPE) || (opcode_i == OP_BEQ) ||
                   (opcode_i == OP_J);
    end

    // Per-state control outputs; anything not set stays 0 (also for unused encodings)
    always_comb begin
        pc_write_o      = 1'b0;
        pc_write_cond_o = 1'b0;
        iord_o          = 1'b0;
        mem_read_o      = 1'b0;
        mem_write_o     = 1'b0;
        ir_write_o      = 1'b0;
        mem_to_reg_o    = 1'b0;
        reg_dst_o       = 1'b0;
        reg_write_o     = 1'b0;
        alu_src_a_o     = 1'b0;
        alu_src_b_o     = SRCB_RT;
        alu_op_o        = ALU_ADD;
        pc_source_o     = PCSRC_ALU;
        instr_done_o    = 1'b0;
        illegal_op_o    = 1'b0;
        case (state_i)
            S_FETCH: begin
                // PC+4 is computed every cycle; only committed when the fetch lands
                mem_read_o  = 1'b1;
                alu_src_b_o = SRCB_FOUR;
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
            end
            S_DECODE: begin
                // Speculative branch target PC + (imm<<2) into ALUOut
                alu_src_b_o  = SRCB_IMM_SH;
                illegal_op_o = !op_known;
                instr_done_o = !op_known;
            end
            S_MEMADR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_IMM;
            end
            S_MEMRD: begin
                mem_read_o = 1'b1;
                iord_o     = 1'b1;
            end
            S_MEMWB: begin
                mem_to_reg_o = 1'b1;
                reg_write_o  = 1'b1;
                instr_done_o = 1'b1;
            end
            S_MEMWR: begin
                mem_write_o  = 1'b1;
                iord_o       = 1'b1;
                instr_done_o = mem_ready_i;
            end
            S_EXECUTE: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = ALU_FUNCT;
            end
            S_ALUWB: begin
                reg_dst_o    = 1'b1;
                reg_write_o  = 1'b1;
                instr_done_o = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_o     = 1'b1;
                alu_op_o        = ALU_SUB;
                pc_write_cond_o = 1'b1;
                pc_source_o     = PCSRC_ALUOUT;
                instr_done_o    = 1'b1;
            end
            S_JUMP: begin
                pc_write_o   = 1'b1;
                pc_source_o  = PCSRC_JUMP;
                instr_done_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS controller: state register and next-state logic. Output
// decode lives in mc_output_decode; enables are gated by reset here so
// nothing writes while rst_n is low, even mid-instruction.
module multicycle_control
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_t state_q, state_d;

    logic pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write;
    logic done, illegal;

    // State register; reset lands in FETCH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Next-state: memory states stall on mem_ready, DECODE dispatches on opcode
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXECUTE: state_d = S_ALUWB;
            default:   state_d = S_FETCH;
        endcase
    end

    mc_output_decode u_dec (
        .state_i         (state_q),
        .mem_ready_i     (mem_ready),
        .opcode_i        (opcode),
        .pc_write_o      (pc_write),
        .pc_write_cond_o (pc_write_cond),
        .iord_o          (IorD),
        .mem_read_o      (mem_read),
        .mem_write_o     (mem_write),
        .ir_write_o      (ir_write),
        .mem_to_reg_o    (MemtoReg),
        .reg_dst_o       (RegDst),
        .reg_write_o     (reg_write),
        .alu_src_a_o     (ALUSrcA),
        .alu_src_b_o     (ALUSrcB),
        .alu_op_o        (ALUOp),
        .pc_source_o     (PCSource),
        .instr_done_o    (done),
        .illegal_op_o    (illegal)
    );

    // Strobes are masked while reset is held so they drop without waiting for a clock
    always_comb begin
        PCWrite     = pc_write      & rst_n;
        PCWriteCond = pc_write_cond & rst_n;
        MemRead     = mem_read      & rst_n;
        MemWrite    = mem_write     & rst_n;
        IRWrite     = ir_write      & rst_n;
        RegWrite    = reg_write     & rst_n;
        instr_done  = done          & rst_n;
        illegal_op  = illegal       & rst_n;
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: each instruction is expanded into
// its expected per-cycle state/control schedule and compared cycle by cycle.
module tb_multicycle_control;
    import mips_pkg::*;

    logic       clk, rst_n, mem_ready;
    logic [5:0] opcode;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, instr_done, illegal_op;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct packed {
        logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
        logic [1:0] srcb, aluop, pcsrc;
        logic       done, ill;
    } ctl_t;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .instr_done(instr_done), .illegal_op(illegal_op),
        .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic ctl_t dut_ctl();
        return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done, illegal_op};
    endfunction

    // Control table straight from the state descriptions; unlisted outputs 0
    function automatic ctl_t exp_ctl(input state_t s, input bit mr, input bit illegal);
        ctl_t c = '0;
        case (s)
            S_FETCH:   begin c.mrd = 1; c.srcb = 2'b01; c.irw = mr; c.pcw = mr; end
            S_DECODE:  begin c.srcb = 2'b11; c.ill = illegal; c.done = illegal; end
            S_MEMADR:  begin c.srca = 1; c.srcb = 2'b10; end
            S_MEMRD:   begin c.mrd = 1; c.iord = 1; end
            S_MEMWB:   begin c.m2r = 1; c.rw = 1; c.done = 1; end
            S_MEMWR:   begin c.mwr = 1; c.iord = 1; c.done = mr; end
            S_EXECUTE: begin c.srca = 1; c.aluop = 2'b10; end
            S_ALUWB:   begin c.rdst = 1; c.rw = 1; c.done = 1; end
            S_BRANCH:  begin c.srca = 1; c.aluop = 2'b01; c.pcwc = 1; c.pcsrc = 2'b01; c.done = 1; end
            S_JUMP:    begin c.pcw = 1; c.pcsrc = 2'b10; c.done = 1; end
            default:   ;
        endcase
        return c;
    endfunction

    state_t qs[$];
    bit     qm[$];

    // Run one instruction: wf fetch stalls, wm data-memory stalls
    task automatic run_instr(input logic [5:0] op, input int wf, input int wm);
        bit   illegal;
        int   base, done_at;
        ctl_t c;
        qs.delete(); qm.delete();
        illegal = !(op inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J});
        for (int i = 0; i < wf; i++) begin qs.push_back(S_FETCH); qm.push_back(1'b0); end
        qs.push_back(S_FETCH);  qm.push_back(1'b1);
        qs.push_back(S_DECODE); qm.push_back(1'($urandom));
        case (op)
            OP_LW: begin
                base = 5;
                qs.push_back(S_MEMADR); qm.push_back(1'($urandom));
                for (int i = 0; i < wm; i++) begin qs.push_back(S_MEMRD); qm.push_back(1'b0); end
                qs.push_back(S_MEMRD); qm.push_back(1'b1);
                qs.push_back(S_MEMWB); qm.push_back(1'($urandom));
            end
            OP_SW: begin
                base = 4;
                qs.push_back(S_MEMADR); qm.push_back(1'($urandom));
                for (int i = 0; i < wm; i++) begin qs.push_back(S_MEMWR); qm.push_back(1'b0); end
                qs.push_back(S_MEMWR); qm.push_back(1'b1);
            end
            OP_RTYPE: begin
                base = 4;
                qs.push_back(S_EXECUTE); qm.push_back(1'($urandom));
                qs.push_back(S_ALUWB);   qm.push_back(1'($urandom));
            end
            OP_BEQ: begin base = 3; qs.push_back(S_BRANCH); qm.push_back(1'($urandom)); end
            OP_J:   begin base = 3; qs.push_back(S_JUMP);   qm.push_back(1'($urandom)); end
            default: base = 2;
        endcase
        if (op != OP_LW && op != OP_SW) wm = 0;
        done_at = -1;
        for (int i = 0; i < qs.size(); i++) begin
            @(negedge clk);
            mem_ready = qm[i];
            opcode    = op;
            #1;
            chk($sformatf("state op=%b cyc=%0d", op, i), 32'(state), 32'(qs[i]));
            c = exp_ctl(qs[i], qm[i], illegal);
            chk($sformatf("ctl op=%b cyc=%0d", op, i), 32'(dut_ctl()), 32'(c));
            if (instr_done && done_at < 0) done_at = i + 1;
        end
        chk($sformatf("cycles op=%b", op), 32'(done_at), 32'(base + wf + wm));
    endtask

    initial begin
        ctl_t rst_ctl;
        logic [5:0] op;
        rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'h3f;
        #3;
        rst_ctl = '0; rst_ctl.srcb = 2'b01;
        chk("reset state", 32'(state), 32'(S_FETCH));
        chk("reset ctl", 32'(dut_ctl()), 32'(rst_ctl));
        mem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Directed: test-plan scenarios
        run_instr(OP_LW, 0, 0);
        run_instr(OP_SW, 0, 2);
        run_instr(OP_RTYPE, 0, 0);
        run_instr(OP_BEQ, 0, 0);
        run_instr(OP_J, 0, 0);
        run_instr(6'b111111, 0, 0);
        run_instr(OP_LW, 2, 3);

        // Random instruction mix with random stalls
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(5))
                0: op = OP_LW;
                1: op = OP_SW;
                2: op = OP_RTYPE;
                3: op = OP_BEQ;
                4: op = OP_J;
                default: begin
                    do op = 6'($urandom);
                    while (op inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J});
                end
            endcase
            run_instr(op, int'($urandom_range(2)), int'($urandom_range(3)));
        end

        // Reset in the middle of a stalled load
        opcode = OP_LW;
        @(negedge clk); mem_ready = 1'b1;  // FETCH
        @(negedge clk);                    // DECODE
        @(negedge clk);                    // MEMADR
        @(negedge clk); mem_ready = 1'b0;  // MEMRD
        #1;
        chk("memrd state", 32'(state), 32'(S_MEMRD));
        chk("memrd MemRead", 32'(MemRead), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst MemRead", 32'(MemRead), 32'd0);
        chk("midrst state", 32'(state), 32'(S_FETCH));
        mem_ready = 1'b1;
        #1;
        chk("midrst ctl", 32'(dut_ctl()), 32'(rst_ctl));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post-rst state", 32'(state), 32'(S_FETCH));
        chk("post-rst IRWrite hi", 32'(IRWrite), 32'd1);
        mem_ready = 1'b0;
        #1;
        chk("post-rst IRWrite lo", 32'(IRWrite), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
